// File: rtl/params_pkg.sv
// Shared widths and enums for the memory port arbiter slice.
package params_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } access_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_req_slot.sv
// One pending-request slot: captures a request pulse, holds it until its
// completion clears it, and flags pulses that arrive while it is full.
module req_slot
   import params_pkg::*;
#(
   parameter int AW = params_pkg::ADDR_WIDTH,
   parameter int DW = params_pkg::DATA_WIDTH
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   input  access_size_t  size_i,
   input  logic          clr_i,
   output logic          pend_o,
   output logic          we_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] wdata_o,
   output access_size_t  size_o,
   output logic          ovf_o
);

   logic          pend_q, pend_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   access_size_t  size_q, size_d;
   logic          ovf_q, ovf_d;

   // A slot that is clearing this edge can take a new pulse in the same edge.
   always_comb begin
      pend_d  = pend_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      ovf_d   = ovf_q | (req_i & pend_q & ~clr_i);
      if (clr_i) pend_d = 1'b0;
      if (req_i && (!pend_q || clr_i)) begin
         pend_d  = 1'b1;
         we_d    = we_i;
         addr_d  = addr_i;
         wdata_d = wdata_i;
         size_d  = size_i;
      end
   end

   // Slot state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= BYTE;
         ovf_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         ovf_q   <= ovf_d;
      end
   end

   assign pend_o  = pend_q;
   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign size_o  = size_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// DM has priority, bounded by a streak limit so a pending IF cannot starve.
module mem_port_arbiter
   import params_pkg::*;
#(
   parameter int ADDR_WIDTH    = params_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH    = params_pkg::DATA_WIDTH,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_rd_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_rsp_valid_o,
   output logic [DATA_WIDTH-1:0] if_rsp_data_o,
   output logic                  if_busy_o,
   input  logic                  dm_rd_req_valid_i,
   input  logic                  dm_wr_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wr_data_i,
   input  access_size_t          dm_access_size_i,
   output logic                  dm_rsp_valid_o,
   output logic [DATA_WIDTH-1:0] dm_rsp_data_o,
   output logic                  dm_busy_o,
   output logic                  mem_req_valid_o,
   output logic                  mem_req_we_o,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
   output access_size_t          mem_req_size_o,
   input  logic                  mem_req_ready_i,
   input  logic                  mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
   output logic                  overflow_err_o
);

   localparam int SW = $clog2(MAX_DM_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

   logic                  if_pend, if_we, if_ovf, if_clr;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_wdata;
   access_size_t          if_size;
   logic                  dm_pend, dm_we, dm_ovf, dm_clr;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   access_size_t          dm_size;

   arb_state_t            state_q, state_d;
   arb_owner_t            owner_q, owner_d, win, sel;
   logic [SW-1:0]         streak_q, streak_d;
   logic                  gnt;
   logic                  both_q;
   logic                  if_rsp_valid_q, dm_rsp_valid_q;
   logic [DATA_WIDTH-1:0] if_rsp_data_q, dm_rsp_data_q;

   req_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_if_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (if_rd_req_valid_i),
      .we_i    (1'b0),
      .addr_i  (if_addr_i),
      .wdata_i ('0),
      .size_i  (WORD),
      .clr_i   (if_clr),
      .pend_o  (if_pend),
      .we_o    (if_we),
      .addr_o  (if_addr),
      .wdata_o (if_wdata),
      .size_o  (if_size),
      .ovf_o   (if_ovf)
   );

   // A simultaneous load and store pulse is treated as a store.
   req_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_dm_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (dm_rd_req_valid_i | dm_wr_req_valid_i),
      .we_i    (dm_wr_req_valid_i),
      .addr_i  (dm_addr_i),
      .wdata_i (dm_wr_data_i),
      .size_i  (dm_access_size_i),
      .clr_i   (dm_clr),
      .pend_o  (dm_pend),
      .we_o    (dm_we),
      .addr_o  (dm_addr),
      .wdata_o (dm_wdata),
      .size_o  (dm_size),
      .ovf_o   (dm_ovf)
   );

   // Arbitration FSM, request mux and streak bookkeeping.
   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      streak_d        = streak_q;
      sel             = owner_q;
      gnt             = 1'b0;
      if_clr          = 1'b0;
      dm_clr          = 1'b0;
      mem_req_valid_o = 1'b0;
      mem_req_we_o    = 1'b0;
      mem_req_addr_o  = '0;
      mem_req_wdata_o = '0;
      mem_req_size_o  = BYTE;
      win = (dm_pend && !(if_pend && streak_q == STREAK_MAX)) ? OWN_DM : OWN_IF;
      case (state_q)
         IDLE: begin
            if (if_pend || dm_pend) begin
               sel             = win;
               owner_d         = win;
               gnt             = 1'b1;
               mem_req_valid_o = 1'b1;
               state_d         = mem_req_ready_i ? WAIT : REQ;
            end
         end
         REQ: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid_i) begin
               if (owner_q == OWN_IF) if_clr = 1'b1;
               else                   dm_clr = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (mem_req_valid_o) begin
         if (sel == OWN_DM) begin
            mem_req_we_o    = dm_we;
            mem_req_addr_o  = dm_addr;
            mem_req_wdata_o = dm_wdata;
            mem_req_size_o  = dm_size;
         end else begin
            mem_req_we_o    = if_we;
            mem_req_addr_o  = if_addr;
            mem_req_wdata_o = if_wdata;
            mem_req_size_o  = if_size;
         end
      end
      if (!if_pend)
         streak_d = '0;
      else if (gnt && win == OWN_DM)
         streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      else if (gnt)
         streak_d = '0;
   end

   // FSM, streak and registered response state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         owner_q        <= OWN_IF;
         streak_q       <= '0;
         both_q         <= 1'b0;
         if_rsp_valid_q <= 1'b0;
         dm_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         dm_rsp_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         streak_q       <= streak_d;
         both_q         <= both_q | (dm_rd_req_valid_i & dm_wr_req_valid_i);
         if_rsp_valid_q <= if_clr;
         dm_rsp_valid_q <= dm_clr & ~dm_we;
         if (if_clr) if_rsp_data_q <= mem_rsp_data_i;
         if (dm_clr && !dm_we) dm_rsp_data_q <= mem_rsp_data_i;
      end
   end

   assign if_rsp_valid_o = if_rsp_valid_q;
   assign if_rsp_data_o  = if_rsp_data_q;
   assign dm_rsp_valid_o = dm_rsp_valid_q;
   assign dm_rsp_data_o  = dm_rsp_data_q;
   assign if_busy_o      = if_pend;
   assign dm_busy_o      = dm_pend;
   assign overflow_err_o = if_ovf | dm_ovf | both_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle memory model.
module tb_mem_port_arbiter;
   import params_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_rd;
   logic [31:0] if_addr;
   logic        if_rsp_valid, if_busy;
   logic [31:0] if_rsp_data;
   logic        dm_rd, dm_wr;
   logic [31:0] dm_addr, dm_wdata;
   access_size_t dm_size;
   logic        dm_rsp_valid, dm_busy;
   logic [31:0] dm_rsp_data;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   access_size_t req_size;
   logic        ready;
   logic        rsp_q = 1'b0, inj;
   logic [31:0] rdata_q = '0;
   logic        ovf;

   int n_chk = 0, n_fail = 0;
   int n_if_rsp = 0, n_dm_rsp = 0, n_coll = 0;
   logic [31:0] gnt_q[$];
   logic [31:0] last_gnt = '0;
   int dm_pulses;
   logic [31:0] exp_seq [6];

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .if_rd_req_valid_i(if_rd), .if_addr_i(if_addr),
      .if_rsp_valid_o(if_rsp_valid), .if_rsp_data_o(if_rsp_data), .if_busy_o(if_busy),
      .dm_rd_req_valid_i(dm_rd), .dm_wr_req_valid_i(dm_wr), .dm_addr_i(dm_addr),
      .dm_wr_data_i(dm_wdata), .dm_access_size_i(dm_size),
      .dm_rsp_valid_o(dm_rsp_valid), .dm_rsp_data_o(dm_rsp_data), .dm_busy_o(dm_busy),
      .mem_req_valid_o(req_valid), .mem_req_we_o(req_we), .mem_req_addr_o(req_addr),
      .mem_req_wdata_o(req_wdata), .mem_req_size_o(req_size),
      .mem_req_ready_i(ready), .mem_rsp_valid_i(rsp_q | inj), .mem_rsp_data_i(rdata_q),
      .overflow_err_o(ovf)
   );

   function automatic logic [31:0] memfn(logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
   endfunction

   // Memory: completes every accepted request one cycle later.
   always @(posedge clk) begin
      rsp_q   <= req_valid & ready;
      rdata_q <= memfn(req_addr);
   end

   // Grant log and response monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (req_valid && ready) begin
         gnt_q.push_back(req_addr);
         last_gnt = req_addr;
      end
      if (if_rsp_valid) n_if_rsp++;
      if (dm_rsp_valid) n_dm_rsp++;
      if (if_rsp_valid && dm_rsp_valid) n_coll++;
   end

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; if_rd = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0;
      dm_wdata = '0; dm_size = WORD; ready = 1'b1; inj = 1'b0;
      step(); step();
      check("rst_req_valid", req_valid, 0);
      check("rst_busy", {if_busy, dm_busy}, 0);
      check("rst_rsp", {if_rsp_valid, dm_rsp_valid, if_rsp_data, dm_rsp_data}, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      step();

      // IF read, best-case latency
      if_rd = 1; if_addr = 32'h100;
      step(); if_rd = 0;
      check("t1_valid", req_valid, 1);
      check("t1_req", {req_addr, 31'd0, req_we}, {32'h100, 32'd0});
      check("t1_size", req_size, WORD);
      check("t1_busy", if_busy, 1);
      step();
      check("t1_wait_valid", req_valid, 0);
      step();
      check("t1_rsp_valid", if_rsp_valid, 1);
      check("t1_rsp_data", if_rsp_data, 32'hDEADBEEF);
      check("t1_busy_clr", if_busy, 0);
      step();
      check("t1_rsp_pulse", if_rsp_valid, 0);
      check("t1_rsp_hold", if_rsp_data, 32'hDEADBEEF);

      // IF and DM load together: DM first
      gnt_q.delete(); n_if_rsp = 0; n_dm_rsp = 0; n_coll = 0;
      if_rd = 1; if_addr = 32'h200; dm_rd = 1; dm_addr = 32'h300;
      step(); if_rd = 0; dm_rd = 0;
      repeat (10) step();
      check("t2_ngnt", gnt_q.size(), 2);
      if (gnt_q.size() == 2) begin
         check("t2_gnt0", gnt_q[0], 32'h300);
         check("t2_gnt1", gnt_q[1], 32'h200);
      end
      check("t2_coll", n_coll, 0);
      check("t2_nrsp", {n_if_rsp[15:0], n_dm_rsp[15:0]}, {16'd1, 16'd1});
      check("t2_dm_data", dm_rsp_data, 32'hA5A50300);
      check("t2_if_data", if_rsp_data, 32'hA5A50200);

      // DM store
      n_dm_rsp = 0;
      dm_wr = 1; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_size = HALF;
      step(); dm_wr = 0;
      check("t3_req", {req_valid, req_we, req_addr, req_wdata}, {2'b11, 32'h40, 32'h12345678});
      check("t3_size", req_size, HALF);
      step();
      check("t3_busy_wait", dm_busy, 1);
      step();
      check("t3_busy_fall", dm_busy, 0);
      step(); step();
      check("t3_no_rsp", n_dm_rsp, 0);
      check("t3_data_hold", dm_rsp_data, 32'hA5A50300);

      // Streak limit: DM re-requests back-to-back while IF waits
      gnt_q.delete(); dm_size = WORD;
      if_rd = 1; if_addr = 32'h600; dm_rd = 1; dm_addr = 32'h500; dm_pulses = 1;
      step(); if_rd = 0; dm_rd = 0;
      for (int c = 0; c < 80 && gnt_q.size() < 6; c++) begin
         dm_rd = (dm_pulses < 5) && (!dm_busy || (rsp_q && last_gnt == 32'h500));
         if (dm_rd) dm_pulses++;
         step(); dm_rd = 0;
      end
      repeat (4) step();
      exp_seq = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h600, 32'h500};
      check("t4_ngnt", gnt_q.size(), 6);
      for (int i = 0; i < 6 && i < gnt_q.size(); i++)
         check($sformatf("t4_gnt%0d", i), gnt_q[i], exp_seq[i]);
      check("t4_streak", dut.streak_q, 0);
      check("t4_ovf", ovf, 0);

      // Ready low for 3 cycles, plus a dropped second DM pulse
      ready = 0; n_dm_rsp = 0;
      dm_rd = 1; dm_addr = 32'h700;
      step(); dm_rd = 0;
      check("t5_c1", {req_valid, req_addr}, {1'b1, 32'h700});
      step();
      check("t5_state", dut.state_q, REQ);
      dm_rd = 1; dm_addr = 32'h7F0;
      step(); dm_rd = 0;
      check("t5_ovf", ovf, 1);
      check("t5_stable", {req_valid, req_we, req_addr}, {2'b10, 32'h700});
      check("t5_size", req_size, WORD);
      step();
      check("t5_state_hold", dut.state_q, REQ);
      ready = 1;
      step(); step();
      check("t5_rsp", {dm_rsp_valid, dm_rsp_data}, {1'b1, 32'hA5A50700});
      step(); step();
      check("t5_ovf_sticky", ovf, 1);
      check("t5_nrsp", n_dm_rsp, 1);

      // Reset in WAIT, then a stray completion
      n_if_rsp = 0;
      if_rd = 1; if_addr = 32'h800;
      step(); if_rd = 0;
      step();
      check("t6_wait", dut.state_q, WAIT);
      rst = 1; #1;
      check("t6_rst_out", {req_valid, if_busy, dm_busy, ovf, if_rsp_valid, dm_rsp_valid}, 0);
      step();
      rst = 0; inj = 1;
      step(); inj = 0;
      check("t6_no_rsp", {if_rsp_valid, dm_rsp_valid}, 0);
      check("t6_idle", {dut.state_q, req_valid, if_busy, dm_busy}, {IDLE, 3'b000});
      check("t6_data", {if_rsp_data, dm_rsp_data}, 0);
      step();
      check("t6_nrsp", n_if_rsp, 0);

      // Load and store together: store wins and flags overflow
      n_dm_rsp = 0;
      dm_rd = 1; dm_wr = 1; dm_addr = 32'h900; dm_wdata = 32'hCAFEF00D;
      step(); dm_rd = 0; dm_wr = 0;
      check("t7_req", {req_valid, req_we, req_addr, req_wdata}, {2'b11, 32'h900, 32'hCAFEF00D});
      check("t7_ovf", ovf, 1);
      repeat (4) step();
      check("t7_no_rsp", n_dm_rsp, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch requester (IF) and the data-memory stage (DM). Each requester issues single-cycle request pulses. The arbiter latches each pulse into a per-port pending slot, grants one request at a time to memory and routes read data back. DM has priority over IF, bounded by an anti-starvation streak limit.

Parameters:
ADDR_WIDTH, params_pkg::ADDR_WIDTH, address width
DATA_WIDTH, params_pkg::DATA_WIDTH, data width
MAX_DM_STREAK, 4, max consecutive DM grants while IF is pending (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
if_rd_req_valid_i  in  1  IF read request pulse
if_addr_i  in  ADDR_WIDTH  IF read address
if_rsp_valid_o  out  1  IF read data valid, 1-cycle pulse
if_rsp_data_o  out  DATA_WIDTH  IF read data
if_busy_o  out  1  IF pending slot occupied
dm_rd_req_valid_i  in  1  DM load request pulse
dm_wr_req_valid_i  in  1  DM store request pulse
dm_addr_i  in  ADDR_WIDTH  DM address
dm_wr_data_i  in  DATA_WIDTH  DM store data
dm_access_size_i  in  access_size_t  DM access size
dm_rsp_valid_o  out  1  DM load data valid, 1-cycle pulse (never for stores)
dm_rsp_data_o  out  DATA_WIDTH  DM load data
dm_busy_o  out  1  DM pending slot occupied
mem_req_valid_o  out  1  request to memory
mem_req_we_o  out  1  1 = write
mem_req_addr_o  out  ADDR_WIDTH  request address
mem_req_wdata_o  out  DATA_WIDTH  write data
mem_req_size_o  out  access_size_t  access size (IF always WORD)
mem_req_ready_i  in  1  memory accepts request this cycle
mem_rsp_valid_i  in  1  memory completion (reads and writes)
mem_rsp_data_i  in  DATA_WIDTH  read data
overflow_err_o  out  1  sticky: request pulse while slot occupied

Behaviour:
- Reset (async, rst_i=1): all outputs 0, pending slots empty, streak counter 0, state IDLE. Reset mid-transaction abandons the transaction. A later mem_rsp_valid_i seen in IDLE is ignored.
- Pending slot per port: stores addr, we, wdata and size, captured at the clock edge of the pulse.
- Slot clears at the edge where that port's mem_rsp_valid_i completes.
- A pulse in the same cycle the slot clears is accepted into the slot.
- A pulse while the slot is occupied and not clearing is dropped and sets overflow_err_o (cleared only by reset).
- dm_rd_req_valid_i and dm_wr_req_valid_i together: the store wins and overflow_err_o is set.
- State machine:
  - IDLE: if any slot pending, select winner and drive mem_req_* from its slot combinationally. With mem_req_ready_i go to WAIT, else go to REQ. Incoming pulses are not eligible until the cycle after capture.
  - REQ: hold the same winner and signals stable until mem_req_ready_i, then go to WAIT.
  - WAIT: mem_req_valid_o=0. On mem_rsp_valid_i, clear owner slot and go to IDLE.
- Arbitration: DM wins unless IF is pending and streak==MAX_DM_STREAK.
- Streak counter: +1 on a DM grant while IF is pending; reset to 0 on an IF grant or when IF is not pending. Saturates at MAX_DM_STREAK. Width $clog2(MAX_DM_STREAK+1).
- Responses are registered: the owner's *_rsp_valid_o pulses 1 cycle after mem_rsp_valid_i for reads. *_rsp_data_o holds its value until the next read response to that port.
- Best-case latency with ready=1 and 1-cycle memory: pulse at N, request at N+1, rsp_valid_i at N+2, *_rsp_valid_o at N+3.
- *_busy_o = slot occupied (registered).

Decomposition:
- params_pkg: reuse access_size_t, WORD, ADDR_WIDTH and DATA_WIDTH. Add arb_state_t {IDLE, REQ, WAIT} and arb_owner_t {OWN_IF, OWN_DM}.
- Sub-module req_slot, instantiated twice: capture, hold, clear and overflow detect.

Test Plan:
- IF read 0x100 only, ready=1, 1-cycle memory returns 0xDEADBEEF -> mem_req_valid_o at N+1 with addr 0x100 we=0 size WORD; if_rsp_valid_o pulse at N+3 with data 0xDEADBEEF.
- IF and DM load pulse same cycle -> DM granted first, IF second; if_rsp_valid_o and dm_rsp_valid_o never in the same cycle.
- DM store 0x40 data 0x12345678 -> mem_req_we_o=1 with those values; no dm_rsp_valid_o; dm_busy_o falls the cycle after mem_rsp_valid_i.
- IF pending, DM re-requests back-to-back, MAX_DM_STREAK=4 -> exactly 4 DM grants, then IF granted, streak resets to 0.
- mem_req_ready_i held low 3 cycles -> state REQ with addr/we/size stable; second DM pulse while busy -> overflow_err_o=1, stays 1.
- Assert rst_i during WAIT, then inject mem_rsp_valid_i -> all outputs 0, no rsp pulse, slots empty.
